tdm_demux: RTL

Time-division demultiplexer: the receiving end of a mux-driven shared line on which CH channels are interleaved one sample per slot, with slot 0 flagged by a sync marker. It hunts for sync, locks to the frame, and steers each accepted sample into its channel holding register. It raises per-channel and per-frame strobes, and flags sync errors. It sits between the shared serial/TDM line and the per-channel consumers.

---
 rtl/tdm_demux_if.sv | 31 +++
 rtl/tdm_demux.sv | 128 ++++++++++++
 2 files changed

// File: rtl/tdm_demux_if.sv
// tdm_demux_if: bundle between a TDM line source and the demultiplexer.
//   in_valid/in_data/in_sync : one slot sample per cycle, in_sync marks slot 0
//   out_data                 : CH holding registers, channel k at [k*WIDTH +: WIDTH]
//   out_valid                : per-channel update strobe
//   frame_valid              : strobe when the last slot of a locked frame lands
//   locked                   : demux is frame-locked
//   sync_err                 : framing violation strobe
// master = line source / consumer side, slave = demultiplexer.
interface tdm_demux_if #(
  parameter int WIDTH = 8,
  parameter int CH    = 2
);
  logic                  in_valid;
  logic [WIDTH-1:0]      in_data;
  logic                  in_sync;
  logic [CH*WIDTH-1:0]   out_data;
  logic [CH-1:0]         out_valid;
  logic                  frame_valid;
  logic                  locked;
  logic                  sync_err;

  modport master (
    output in_valid, in_data, in_sync,
    input  out_data, out_valid, frame_valid, locked, sync_err
  );

  modport slave (
    input  in_valid, in_data, in_sync,
    output out_data, out_valid, frame_valid, locked, sync_err
  );
endinterface

// File: rtl/tdm_demux.sv
// tdm_demux: receiving end of a shared TDM line carrying CH interleaved channels.
// Hunts for the slot-0 sync marker, locks to the frame, and steers each sample
// into its channel holding register. All outputs are registered (1-cycle latency).
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : tdm_demux_if slave modport (sample input, holding registers, strobes)
module tdm_demux #(
  parameter int WIDTH = 8,
  parameter int CH    = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  tdm_demux_if.slave   bus
);

  localparam int SLOT_W = (CH > 1) ? $clog2(CH) : 1;
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(CH - 1);
  localparam logic [SLOT_W-1:0] SLOT_ONE  = SLOT_W'(1);

  typedef enum logic {HUNT = 1'b0, LOCK = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;

  logic                wr_en;
  logic [SLOT_W-1:0]   wr_slot;
  logic                fv_d;
  logic                err_d;

  logic [CH-1:0][WIDTH-1:0] data_p1;
  logic [CH-1:0]            vld_p1;
  logic                     fv_p1;
  logic                     err_p1;
  logic                     lock_p1;

  // ---- stage p0: frame state register ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= HUNT;
      slot_q  <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
    end
  end

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    if (bus.in_valid) begin
      unique case (state_q)
        HUNT: begin
          if (bus.in_sync) begin
            state_d = LOCK;
            slot_d  = SLOT_ONE;
          end
        end
        LOCK: begin
          if (bus.in_sync) begin
            // expected or early sync both realign to slot 1
            slot_d = SLOT_ONE;
          end else if (slot_q == '0) begin
            // slot 0 arrived without its marker: lose lock
            state_d = HUNT;
            slot_d  = '0;
          end else begin
            slot_d = (slot_q == LAST_SLOT) ? '0 : slot_q + SLOT_ONE;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    wr_en   = 1'b0;
    wr_slot = '0;
    fv_d    = 1'b0;
    err_d   = 1'b0;
    if (bus.in_valid) begin
      unique case (state_q)
        HUNT: begin
          wr_en = bus.in_sync;
        end
        LOCK: begin
          if (bus.in_sync) begin
            wr_en = 1'b1;
            err_d = (slot_q != '0);
          end else if (slot_q == '0) begin
            err_d = 1'b1;
          end else begin
            wr_en   = 1'b1;
            wr_slot = slot_q;
            fv_d    = (slot_q == LAST_SLOT);
          end
        end
        default: ;
      endcase
    end
  end

  // ---- stage p1: registered holding registers and strobes ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_p1 <= '0;
      vld_p1  <= '0;
      fv_p1   <= 1'b0;
      err_p1  <= 1'b0;
      lock_p1 <= 1'b0;
    end else begin
      vld_p1 <= '0;
      if (wr_en) begin
        data_p1[wr_slot] <= bus.in_data;
        vld_p1[wr_slot]  <= 1'b1;
      end
      fv_p1   <= fv_d;
      err_p1  <= err_d;
      lock_p1 <= (state_d == LOCK);
    end
  end

  assign bus.out_data    = data_p1;
  assign bus.out_valid   = vld_p1;
  assign bus.frame_valid = fv_p1;
  assign bus.sync_err    = err_p1;
  assign bus.locked      = lock_p1;

endmodule
